// File: rtl/nexi_uart_tx_arbiter.sv
// Round-robin arbiter sharing one nexi_uart_tx between NUM_REQ requesters.
// Owns the command_send / done_ack handshake and returns per-requester done/err pulses.
module nexi_uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          done,
  output logic [NUM_REQ-1:0]          err,
  output logic                        busy,
  output logic                        tx_command_send,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_done_ack
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StSend     = 2'd1;
  localparam logic [1:0] StWaitDone = 2'd2;
  localparam logic [1:0] StHoldoff  = 2'd3;

  logic [1:0]         state_q,   state_d;
  logic [PtrW-1:0]    rr_ptr_q,  rr_ptr_d;
  logic [PtrW-1:0]    cur_q,     cur_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic [CntW-1:0]    tout_q,    tout_d;
  logic [NUM_REQ-1:0] gnt_q,     gnt_d;
  logic [NUM_REQ-1:0] done_q,    done_d;
  logic [NUM_REQ-1:0] err_q,     err_d;
  logic               cmd_q,     cmd_d;

  logic               win_vld;
  logic [PtrW-1:0]    win_idx;
  logic [DATA_W-1:0]  win_data;
  int unsigned        cand;

  // First requester after the last-served index, wrapping modulo NUM_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_vld && req[PtrW'(cand)]) begin
        win_vld = 1'b1;
        win_idx = PtrW'(cand);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (PtrW'(i) == win_idx) begin
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cur_d     = cur_q;
    tx_data_d = tx_data_q;
    tout_d    = tout_q;
    gnt_d     = gnt_q;
    cmd_d     = cmd_q;
    done_d    = '0;
    err_d     = '0;
    unique case (state_q)
      StIdle: begin
        if (tx_done_ack && win_vld) begin
          cur_d          = win_idx;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          tx_data_d      = win_data;
          cmd_d          = 1'b1;
          tout_d         = '0;
          state_d        = StSend;
        end
      end
      StSend: begin
        if (!tx_done_ack) begin
          cmd_d   = 1'b0;
          state_d = StWaitDone;
        end else if (tout_q == CntW'(ACK_TIMEOUT - 1)) begin
          // TX never left idle: give up on this byte and report it.
          cmd_d        = 1'b0;
          gnt_d        = '0;
          err_d[cur_q] = 1'b1;
          rr_ptr_d     = cur_q;
          state_d      = StHoldoff;
        end else begin
          tout_d = tout_q + CntW'(1);
        end
      end
      StWaitDone: begin
        if (tx_done_ack) begin
          gnt_d         = '0;
          done_d[cur_q] = 1'b1;
          rr_ptr_d      = cur_q;
          state_d       = StHoldoff;
        end
      end
      StHoldoff: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      cur_q     <= '0;
      tx_data_q <= '0;
      tout_q    <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      cmd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      cur_q     <= cur_d;
      tx_data_q <= tx_data_d;
      tout_q    <= tout_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cmd_q     <= cmd_d;
    end
  end

  assign gnt             = gnt_q;
  assign done            = done_q;
  assign err             = err_q;
  assign busy            = (state_q != StIdle);
  assign tx_command_send = cmd_q;
  assign tx_data         = tx_data_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_resp_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0({done_q, err_q}));
  a_cmd_in_send: assert property (@(posedge clk) disable iff (!rst_n)
                                  cmd_q |-> (state_q == StSend));

endmodule

// File: tb/tb_nexi_uart_tx_arbiter.sv
// Scoreboard bench for nexi_uart_tx_arbiter: a driver predicts each transfer from a
// round-robin model, a TX model answers the handshake, a monitor checks every grant and pulse.
module tb_nexi_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int AckTo = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt, done, err;
  logic           busy, tx_command_send;
  logic [W-1:0]   tx_data;
  logic           tx_ack_q;
  logic           force_busy;
  logic           tx_done_ack;

  assign tx_done_ack = tx_ack_q & ~force_busy;

  always #5 clk = ~clk;

  nexi_uart_tx_arbiter #(
    .NUM_REQ    (N),
    .DATA_W     (W),
    .ACK_TIMEOUT(AckTo)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_data       (req_data),
    .gnt            (gnt),
    .done           (done),
    .err            (err),
    .busy           (busy),
    .tx_command_send(tx_command_send),
    .tx_data        (tx_data),
    .tx_done_ack    (tx_done_ack)
  );

  typedef struct {
    int           idx;
    logic [W-1:0] data;
    bit           refuse;
    int           ack_dly;
    int           frame;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t plan_q[$];
  int    checks = 0;
  int    fails  = 0;
  int    model_last = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Next requester served: first pending one after the last served, wrapping.
  function automatic int pick(input logic [N-1:0] pend);
    for (int k = 1; k <= N; k++) begin
      int c = (model_last + k) % N;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  task automatic expect_next(input bit refuse, input int ack_dly, input int frame);
    xfer_t x;
    int    w;
    w = pick(req);
    if (w < 0) begin
      fail_now("no_requester_to_predict");
      return;
    end
    x.idx     = w;
    x.data    = req_data[w*W +: W];
    x.refuse  = refuse;
    x.ack_dly = ack_dly;
    x.frame   = frame;
    exp_q.push_back(x);
    plan_q.push_back(x);
    model_last = w;
  endtask

  task automatic set_req(input int i, input bit on, input logic [W-1:0] d);
    req[i] = on;
    req_data[i*W +: W] = d;
  endtask

  task automatic wait_pulse(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if ((done | err) != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("pulse_timeout");
  endtask

  task automatic wait_cmd(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tx_command_send) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("cmd_timeout");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    model_last = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // TX model: follows the plan attached to each predicted transfer.
  initial begin
    xfer_t p;
    tx_ack_q = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && tx_command_send) begin
        if (plan_q.size() > 0) begin
          p = plan_q.pop_front();
        end else begin
          p.refuse  = 1'b0;
          p.ack_dly = 1;
          p.frame   = 4;
        end
        if (p.refuse) begin
          for (int c = 0; c < 50 && tx_command_send; c++) @(negedge clk);
        end else begin
          repeat (p.ack_dly - 1) @(negedge clk);
          tx_ack_q = 1'b0;
          repeat (p.frame) @(negedge clk);
          tx_ack_q = 1'b1;
        end
      end
    end
  end

  // Monitor: checks each command start, command length, response pulse and return to idle.
  initial begin
    xfer_t      e;
    bit         prev_cmd;
    bit         post;
    int         cmd_len;
    logic [N-1:0] oh;
    prev_cmd = 1'b0;
    post     = 1'b0;
    cmd_len  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cmd = 1'b0;
        post     = 1'b0;
        cmd_len  = 0;
        continue;
      end
      if (post) begin
        chk("busy_after_holdoff", {31'b0, busy}, 32'd0);
        post = 1'b0;
      end
      if (tx_command_send) begin
        if (!prev_cmd) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_command");
          end else begin
            e  = exp_q[0];
            oh = '0;
            oh[e.idx] = 1'b1;
            chk("gnt_at_cmd", 32'(gnt), 32'(oh));
            chk("data_at_cmd", 32'(tx_data), 32'(e.data));
          end
        end
        cmd_len++;
      end else if (prev_cmd) begin
        chk("cmd_len", cmd_len, e.refuse ? AckTo : e.ack_dly);
        cmd_len = 0;
      end
      prev_cmd = tx_command_send;
      if ((done | err) != '0) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_done_err");
        end else begin
          e  = exp_q.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          chk("done_vec", 32'(done), e.refuse ? 32'd0 : 32'(oh));
          chk("err_vec", 32'(err), e.refuse ? 32'(oh) : 32'd0);
          chk("data_held", 32'(tx_data), 32'(e.data));
          chk("gnt_in_holdoff", 32'(gnt), 32'd0);
          post = 1'b1;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int served;
    rst_n      = 1'b0;
    req        = '0;
    req_data   = '0;
    force_busy = 1'b0;

    // Reset state
    #12;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_cmd", {31'b0, tx_command_send}, 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: single request, one-cycle latency to command
    @(negedge clk);
    set_req(0, 1'b1, 8'h33);
    expect_next(1'b0, 2, 20);
    @(negedge clk);
    chk("t1_cmd_latency", {31'b0, tx_command_send}, 32'd1);
    chk("t1_data_latency", 32'(tx_data), 32'h33);
    wait_pulse(ok);
    req = '0;
    repeat (3) @(negedge clk);

    // T2: all requesting after reset, order 1,2,3,0,1,2
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(8'h10 + i));
    expect_next(1'b0, 1, 3);
    for (int t = 0; t < 6; t++) begin
      wait_pulse(ok);
      if (!ok) break;
      if (t == 5) req = '0;
      else expect_next(1'b0, 1 + (t % 2), 3);
    end
    repeat (3) @(negedge clk);

    // T3: TX never acknowledges
    set_req(2, 1'b1, 8'h5C);
    expect_next(1'b1, 1, 0);
    wait_pulse(ok);
    req = '0;
    repeat (3) @(negedge clk);

    // T4: TX busy while idle holds off arbitration
    force_busy = 1'b1;
    set_req(1, 1'b1, 8'h42);
    expect_next(1'b0, 1, 6);
    repeat (5) begin
      @(negedge clk);
      chk("t4_no_gnt", 32'(gnt), 32'd0);
      chk("t4_no_cmd", {31'b0, tx_command_send}, 32'd0);
    end
    force_busy = 1'b0;
    @(negedge clk);
    chk("t4_cmd_after_ack", {31'b0, tx_command_send}, 32'd1);
    chk("t4_gnt_after_ack", 32'(gnt), 32'h2);
    wait_pulse(ok);
    req = '0;
    repeat (3) @(negedge clk);

    // T5: asynchronous reset during WAIT_DONE
    set_req(3, 1'b1, 8'hAB);
    expect_next(1'b0, 1, 30);
    wait_cmd(ok);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_gnt", 32'(gnt), 32'd0);
    chk("t5_cmd", {31'b0, tx_command_send}, 32'd0);
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_data", 32'(tx_data), 32'd0);
    chk("t5_resp", 32'({done, err}), 32'd0);
    exp_q.delete();
    model_last = 0;
    req = '0;
    set_req(0, 1'b1, 8'h5A);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_next(1'b0, 1, 5);
    wait_pulse(ok);
    req = '0;
    repeat (3) @(negedge clk);

    // T6: requester drops req and changes data mid-transfer
    set_req(0, 1'b1, 8'h77);
    expect_next(1'b0, 1, 12);
    wait_cmd(ok);
    repeat (3) @(negedge clk);
    set_req(0, 1'b0, 8'hEE);
    wait_pulse(ok);
    repeat (3) @(negedge clk);

    // Randomized traffic: requesters join and leave only around response pulses
    req = N'($urandom_range(1, (1 << N) - 1));
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
    expect_next($urandom_range(0, 5) == 0, $urandom_range(1, 3), $urandom_range(2, 10));
    for (int t = 0; t < 40; t++) begin
      wait_pulse(ok);
      if (!ok) break;
      served = model_last;
      if ($urandom_range(0, 1) == 1) req[served] = 1'b0;
      else req_data[served*W +: W] = W'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!req[i] && i != served && $urandom_range(0, 3) == 0) begin
          set_req(i, 1'b1, W'($urandom));
        end
      end
      if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
      if (t == 39) req = '0;
      else expect_next($urandom_range(0, 5) == 0, $urandom_range(1, 3), $urandom_range(2, 10));
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
